// File: rtl/cadr_cycle_sequencer.sv
// Synchronous CADR machine-cycle generator: counts fast clock ticks to produce TPR/TPW strobes.
// Optional single-step control is compiled in when CADR_CLK_SINGLE_STEP_EN is defined.
module cadr_cycle_sequencer #(
  parameter int CNT_W    = 6,
  parameter int TPR40_T  = 8,
  parameter int TPR60_T  = 12,
  parameter int WP_START = 4,
  parameter int WP_END   = 10,
  parameter int TPW_DONE = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        hang,
  input  logic [1:0]  sspeed,
  input  logic        ilong,
  input  logic        step,
  output logic        tpr0,
  output logic        tpr40,
  output logic        tpr60,
  output logic        tprend,
  output logic        tpclk,
  output logic        tpwp,
  output logic        tpdone,
  output logic        busy,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [CNT_W-1:0]   rlen_q, rlen_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               start_ok;
  logic [CNT_W-1:0]   done_t;
  logic [CNT_W-1:0]   wp_lo;
  logic [CNT_W-1:0]   wp_hi;

  // Read-phase length in ticks, replacing the delay-line tap selection.
  function automatic logic [CNT_W-1:0] read_len(input logic [1:0] sp, input logic il);
    case ({sp, il})
      3'b000, 3'b001: read_len = CNT_W'(32);
      3'b011:         read_len = CNT_W'(28);
      3'b010:         read_len = CNT_W'(20);
      3'b101:         read_len = CNT_W'(25);
      3'b100:         read_len = CNT_W'(17);
      3'b111:         read_len = CNT_W'(23);
      default:        read_len = CNT_W'(15);
    endcase
  endfunction

  assign done_t = rlen_q + CNT_W'(TPW_DONE);
  assign wp_lo  = rlen_q + CNT_W'(WP_START);
  assign wp_hi  = rlen_q + CNT_W'(WP_END);

`ifdef CADR_CLK_SINGLE_STEP_EN
  logic step_prev_q, step_prev_d;
  logic step_pend_q, step_pend_d;
  logic step_rise;

  assign step_rise = step & ~step_prev_q;
  assign start_ok  = ~hang & (run | step_pend_q | step_rise);

  // A step edge is remembered only while stopped; edges during a cycle are dropped.
  always_comb begin
    step_prev_d = step;
    step_pend_d = 1'b0;
    if (state_q == IDLE || state_q == HOLD)
      step_pend_d = (step_pend_q | step_rise) & ~start_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
      step_pend_q <= step_pend_d;
    end
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign start_ok    = run & ~hang;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    rlen_d  = rlen_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HOLD: begin
        if (start_ok) begin
          state_d = READ;
          tick_d  = '0;
          rlen_d  = read_len(sspeed, ilong);
        end
      end
      READ: begin
        tick_d = tick_q + CNT_W'(1);
        if (tick_q == rlen_q) state_d = WRITE;
      end
      WRITE: begin
        if (tick_q == done_t) begin
          cnt_d = cnt_q + 16'd1;
          // Stall and stop only take effect here, at the cycle boundary.
          if (run & ~hang) begin
            state_d = READ;
            tick_d  = '0;
            rlen_d  = read_len(sspeed, ilong);
          end else begin
            state_d = HOLD;
            tick_d  = '0;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      rlen_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      rlen_q  <= rlen_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tpr0      = (state_q == READ) && (tick_q == '0);
  assign tpr40     = (state_q == READ) && (tick_q == CNT_W'(TPR40_T));
  assign tpr60     = (state_q == READ) && (tick_q == CNT_W'(TPR60_T));
  assign tprend    = (state_q == READ) && (tick_q == rlen_q);
  assign tpclk     = tprend || (state_q == WRITE);
  assign tpwp      = (state_q == WRITE) && (tick_q >= wp_lo) && (tick_q < wp_hi);
  assign tpdone    = (state_q == WRITE) && (tick_q == done_t);
  assign busy      = (state_q == READ) || (state_q == WRITE);
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cadr_cycle_sequencer.sv
// Scoreboard bench for cadr_cycle_sequencer: stimulus queues expected strobe events, a monitor pops and compares.
module tb_cadr_cycle_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, hang, ilong, step;
  logic [1:0]  sspeed;
  logic        tpr0, tpr40, tpr60, tprend, tpclk, tpwp, tpdone, busy;
  logic [15:0] cycle_cnt;

  cadr_cycle_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .hang(hang), .sspeed(sspeed), .ilong(ilong),
    .step(step), .tpr0(tpr0), .tpr40(tpr40), .tpr60(tpr60), .tprend(tprend),
    .tpclk(tpclk), .tpwp(tpwp), .tpdone(tpdone), .busy(busy), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_TPR0, K_END, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    int    t;
    int    cnt;
  } ev_t;

  ev_t q[$];
  int  clk_n = 0;
  int  checks = 0;
  int  errors = 0;
  int  next_t0, last_t0, exp_cnt;

  always @(posedge clk) clk_n <= clk_n + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (clk %0d)", name, got, exp, clk_n);
    end
  endtask

  task automatic push_cycle(input int r, input bit full);
    ev_t e;
    last_t0 = next_t0;
    e.kind = K_TPR0; e.t = next_t0;         e.cnt = exp_cnt; q.push_back(e);
    e.kind = K_END;  e.t = next_t0 + r;     e.cnt = exp_cnt; q.push_back(e);
    if (full) begin
      e.kind = K_DONE; e.t = next_t0 + r + 12; e.cnt = exp_cnt; q.push_back(e);
      exp_cnt++;
      next_t0 = next_t0 + r + 13;
    end
  endtask

  task automatic wait_to(input int t);
    while (clk_n < t) @(negedge clk);
  endtask

  task automatic pop_check(input kind_t k, input string name);
    ev_t e;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s unexpected: got strobe expected none (clk %0d)", name, clk_n);
    end else begin
      e = q.pop_front();
      chk({name, "_kind"}, int'(k), int'(e.kind));
      chk({name, "_time"}, clk_n, e.t);
      if (k != K_END) chk({name, "_cycle_cnt"}, int'(cycle_cnt), e.cnt);
    end
  endtask

  // Monitor: per-cycle strobe ordering and phase widths, plus scoreboard pops.
  initial begin
    int rel = 0, r_rel = 0, wp_first = -1, wp_cnt = 0, clk_cnt = 0, clk_first = -1;
    forever begin
      @(posedge clk); #1;
      if (tpr0) begin
        pop_check(K_TPR0, "tpr0");
        chk("busy_at_tpr0", int'(busy), 1);
        rel = 0; wp_cnt = 0; clk_cnt = 0; wp_first = -1; clk_first = -1;
      end
      if (tpr40) chk("tpr40_offset", rel, 8);
      if (tpr60) chk("tpr60_offset", rel, 12);
      if (tprend) begin
        pop_check(K_END, "tprend");
        r_rel = rel;
      end
      if (tpwp) begin
        if (wp_first < 0) wp_first = rel;
        wp_cnt++;
      end
      if (tpclk) begin
        if (clk_first < 0) clk_first = rel;
        clk_cnt++;
      end
      if (tpdone) begin
        pop_check(K_DONE, "tpdone");
        chk("tpwp_width", wp_cnt, 6);
        chk("tpwp_start", wp_first, r_rel + 4);
        chk("tpclk_width", clk_cnt, 13);
        chk("tpclk_start", clk_first, r_rel);
        chk("busy_at_tpdone", int'(busy), 1);
      end
      rel++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b1; hang = 1'b0; sspeed = 2'b00; ilong = 1'b1; step = 1'b0;
    exp_cnt = 0;
    // Outputs held low during reset.
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_outputs", int'({tpr0, tpr40, tpr60, tprend, tpclk, tpwp, tpdone, busy}), 0);
      chk("reset_cycle_cnt", int'(cycle_cnt), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    next_t0 = clk_n + 1;

    // 00/1 then 11/0 (changed mid-cycle, takes effect next TPR0), then 01/1 changed at tick 5.
    push_cycle(32, 1'b1);
    wait_to(last_t0 + 16);
    sspeed = 2'b11; ilong = 1'b0;
    push_cycle(15, 1'b1);
    wait_to(last_t0 + 5);
    sspeed = 2'b01; ilong = 1'b1;
    push_cycle(28, 1'b1);

    // hang at tick 10: cycle completes, then stall until hang drops.
    wait_to(last_t0 + 10);
    hang = 1'b1;
    wait_to(last_t0 + 60);
    chk("hold_busy", int'(busy), 0);
    hang = 1'b0;
    next_t0 = clk_n + 1;
    push_cycle(28, 1'b0);

    // Reset at tick R+5 aborts the write phase immediately.
    wait_to(last_t0 + 33);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", int'({tpclk, tpwp, busy}), 0);
    chk("abort_cycle_cnt", int'(cycle_cnt), 0);
    @(negedge clk);
    reset = 1'b0; sspeed = 2'b10; ilong = 1'b1;
    exp_cnt = 0;
    next_t0 = clk_n + 1;
    push_cycle(25, 1'b1);
    push_cycle(25, 1'b1);
    wait_to(last_t0 + 3);
    run = 1'b0;
    wait_to(last_t0 + 60);

`ifdef CADR_CLK_SINGLE_STEP_EN
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      next_t0 = clk_n + 1;
      push_cycle(25, 1'b1);
      @(negedge clk);
      step = 1'b0;
      wait_to(last_t0 + 10);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      wait_to(last_t0 + 100);
    end
`else
    step = 1'b1;
    repeat (3) @(negedge clk);
    step = 1'b0;
    repeat (60) @(negedge clk);
`endif

    chk("queue_drained", q.size(), 0);
    chk("final_cycle_cnt", int'(cycle_cnt), exp_cnt);
    chk("final_busy", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
